// File: rtl/memory_access_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : memory_access_stage
// Purpose  : LEGv8 MEM-stage controller: variable-latency data-memory access,
//            pipeline stall, branch resolution, misalign/timeout reporting.
// Revision : 1.0  initial release
// ============================================================================
module memory_access_stage #(
    parameter int N       = 64,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_M,
    input  logic         Branch_M,
    input  logic         MemRead_M,
    input  logic         MemWrite_M,
    input  logic         zero_M,
    input  logic [N-1:0] aluResult_M,
    input  logic [N-1:0] writeData_M,
    input  logic [N-1:0] PCBranch_M,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic         dm_ready,
    input  logic         dm_rvalid,
    input  logic [N-1:0] dm_rdata,
    output logic [N-1:0] readData_M,
    output logic         PCSrc_M,
    output logic [N-1:0] PCBranch_out,
    output logic         stall_M,
    output logic         done_M,
    output logic [1:0]   err_M
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [15:0] c_CNT_LAST = 16'(TIMEOUT - 1);
    localparam logic [1:0]  c_ERR_NONE = 2'b00;
    localparam logic [1:0]  c_ERR_MIS  = 2'b01;
    localparam logic [1:0]  c_ERR_TO   = 2'b10;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic [N-1:0] r_addr;
    logic [N-1:0] r_wdata;
    logic        r_we;
    logic [N-1:0] r_rdata;
    logic [1:0]  r_err;

    logic        w_mem;
    logic        w_misal;
    logic        w_cnt_last;
    logic        w_req;
    logic        w_stall;
    logic        w_done;
    logic        w_latch;
    logic        w_capture;
    logic        w_set_err;
    logic [1:0]  w_err_nxt;

    assign w_mem      = MemRead_M | MemWrite_M;
    assign w_misal    = |aluResult_M[2:0];
    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_next    = r_state;
        w_req     = 1'b0;
        w_stall   = 1'b0;
        w_done    = 1'b0;
        w_latch   = 1'b0;
        w_capture = 1'b0;
        w_set_err = 1'b0;
        w_err_nxt = c_ERR_NONE;
        case (r_state)
            IDLE: begin
                if (valid_M) begin
                    if (!w_mem) begin
                        w_done    = 1'b1;
                        w_set_err = 1'b1;
                    end else if (w_misal) begin
                        w_done    = 1'b1;
                        w_set_err = 1'b1;
                        w_err_nxt = c_ERR_MIS;
                    end else begin
                        w_stall = 1'b1;
                        w_latch = 1'b1;
                        w_next  = REQ;
                    end
                end
            end
            REQ: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (dm_ready) begin
                    // A store is finished once accepted; a load still owes data.
                    w_next    = r_we ? RESP : WAIT_R;
                    w_set_err = r_we;
                end else if (w_cnt_last) begin
                    w_next    = RESP;
                    w_set_err = 1'b1;
                    w_err_nxt = c_ERR_TO;
                end
            end
            WAIT_R: begin
                w_stall = 1'b1;
                if (dm_rvalid) begin
                    w_capture = 1'b1;
                    w_set_err = 1'b1;
                    w_next    = RESP;
                end else if (w_cnt_last) begin
                    w_set_err = 1'b1;
                    w_err_nxt = c_ERR_TO;
                    w_next    = RESP;
                end
            end
            RESP: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
            r_err   <= c_ERR_NONE;
        end else begin
            r_state <= w_next;
            // Any state change restarts the wait counter for the new state.
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state == REQ || r_state == WAIT_R) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_latch) begin
                r_addr  <= aluResult_M;
                r_wdata <= writeData_M;
                r_we    <= MemWrite_M;
            end
            if (w_capture) begin
                r_rdata <= dm_rdata;
            end
            if (w_set_err) begin
                r_err <= w_err_nxt;
            end
        end
    end

    // Handshake outputs are forced low while reset is held, whatever the state.
    assign dm_req       = w_req & reset;
    assign stall_M      = w_stall & reset;
    assign done_M       = w_done & reset;
    assign dm_we        = r_we;
    assign dm_addr      = r_addr;
    assign dm_wdata     = r_wdata;
    assign readData_M   = r_rdata;
    assign err_M        = r_err;
    assign PCSrc_M      = valid_M & Branch_M & zero_M;
    assign PCBranch_out = PCBranch_M;

endmodule
`default_nettype wire

// File: tb/tb_memory_access_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_memory_access_stage
// Purpose  : Scoreboard bench for memory_access_stage with randomized traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_memory_access_stage;

    localparam int N  = 64;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         valid_M = 1'b0, Branch_M = 1'b0, MemRead_M = 1'b0, MemWrite_M = 1'b0, zero_M = 1'b0;
    logic [N-1:0] aluResult_M = '0, writeData_M = '0, PCBranch_M = '0;
    logic         dm_req, dm_we;
    logic [N-1:0] dm_addr, dm_wdata;
    logic         dm_ready = 1'b0, dm_rvalid = 1'b0;
    logic [N-1:0] dm_rdata = '0;
    logic [N-1:0] readData_M, PCBranch_out;
    logic         PCSrc_M, stall_M, done_M;
    logic [1:0]   err_M;

    memory_access_stage #(.N(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .valid_M(valid_M), .Branch_M(Branch_M),
        .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M), .zero_M(zero_M),
        .aluResult_M(aluResult_M), .writeData_M(writeData_M), .PCBranch_M(PCBranch_M),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .readData_M(readData_M), .PCSrc_M(PCSrc_M), .PCBranch_out(PCBranch_out),
        .stall_M(stall_M), .done_M(done_M), .err_M(err_M)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        we;
        logic        has_req;
        int          issue;
        int          lat;
        logic [1:0]  err;
        logic [63:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          rst_edges = 0;
    logic [63:0] model_rd = '0;
    logic        err_pend = 1'b0;
    logic [1:0]  err_exp = 2'b00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) rst_edges <= rst_edges + 1;
        else        rst_edges <= 0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compares every memory request and completion against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_dm_req", 64'(dm_req), 64'd0);
            chk("rst_stall", 64'(stall_M), 64'd0);
            chk("rst_done", 64'(done_M), 64'd0);
            if (rst_edges > 0) begin
                chk("rst_readData", readData_M, 64'd0);
                chk("rst_err", 64'(err_M), 64'd0);
            end
            sb.delete();
            err_pend = 1'b0;
        end else begin
            if (err_pend) begin
                chk("err_M", 64'(err_M), 64'(err_exp));
                err_pend = 1'b0;
            end
            if (dm_req) begin
                chk("req_stall", 64'(stall_M), 64'd1);
                chk("req_pending", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    chk("req_expected", 64'(dm_req), 64'(sb[0].has_req));
                    if (dm_ready && sb[0].has_req) begin
                        chk("dm_addr", dm_addr, sb[0].addr);
                        chk("dm_we", 64'(dm_we), 64'(sb[0].we));
                        if (sb[0].we) chk("dm_wdata", dm_wdata, sb[0].wdata);
                    end
                end
            end
            if (done_M) begin
                chk("done_pending", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", 64'(cyc - e.issue), 64'(e.lat));
                    chk("readData", readData_M, e.rdata);
                    chk("done_stall", 64'(stall_M), 64'd0);
                    err_exp  = e.err;
                    err_pend = 1'b1;
                end
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b0; valid_M = 1'b0; MemRead_M = 1'b0; MemWrite_M = 1'b0;
        dm_ready = 1'b0; dm_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_rd = '0;
    endtask

    // kind: 0 non-memory, 1 load, 2 store. dr = REQ cycles before dm_ready,
    // dv = WAIT_R cycles before dm_rvalid. noise pulses rvalid in the accept cycle.
    task automatic run_instr(input int kind, input logic [63:0] addr, input logic [63:0] wd,
                             input logic br, input logic zr, input int dr, input int dv,
                             input logic [63:0] rd, input logic noise);
        exp_t e;
        int   r;
        int   r_pend;
        logic seen;
        logic mem;
        logic misal;
        mem   = (kind != 0);
        misal = (addr[2:0] != 3'd0);
        e.addr    = addr;
        e.wdata   = wd;
        e.we      = (kind == 2);
        e.has_req = mem && !misal;
        e.err     = 2'b00;
        if (!mem) begin
            e.lat = 0;
        end else if (misal) begin
            e.lat = 0; e.err = 2'b01;
        end else if (dr >= TO) begin
            e.lat = 1 + TO; e.err = 2'b10;
        end else if (kind == 2) begin
            e.lat = 2 + dr;
        end else if (dv >= TO) begin
            e.lat = 2 + dr + TO; e.err = 2'b10;
        end else begin
            e.lat = 3 + dr + dv;
            model_rd = rd;
        end
        e.rdata = model_rd;
        r_pend = !e.has_req ? 0 : (kind == 2 ? 1 + dr : 2 + dr + dv);

        @(posedge clk); #1;
        valid_M = 1'b1; Branch_M = br; zero_M = zr;
        MemRead_M = (kind == 1); MemWrite_M = (kind == 2);
        aluResult_M = addr; writeData_M = wd; PCBranch_M = {$urandom(), $urandom()};
        dm_ready = 1'b0; dm_rvalid = 1'b0; dm_rdata = {$urandom(), $urandom()};
        e.issue = cyc;
        sb.push_back(e);
        seen = 1'b0;
        r = 0;
        @(negedge clk);
        chk("PCSrc_M", 64'(PCSrc_M), 64'(br & zr));
        chk("PCBranch_out", PCBranch_out, PCBranch_M);
        if (done_M) seen = 1'b1;
        while (1) begin
            @(posedge clk); #1;
            r++;
            if (seen) begin
                valid_M = 1'b0; Branch_M = 1'b0; MemRead_M = 1'b0; MemWrite_M = 1'b0;
            end
            dm_ready  = e.has_req && (r >= 1 + dr);
            dm_rvalid = (kind == 1) && e.has_req && ((r == 2 + dr + dv) || (noise && r == 1 + dr));
            dm_rdata  = (r == 2 + dr + dv) ? rd : {$urandom(), $urandom()};
            if (seen && r > r_pend) break;
            if (r > 80) begin
                chk("done_within_bound", 64'(seen), 64'd1);
                apply_reset();
                break;
            end
            @(negedge clk);
            if (done_M) seen = 1'b1;
        end
    endtask

    initial begin
        // Reset held with a live load presented.
        reset = 1'b0; valid_M = 1'b1; MemRead_M = 1'b1; aluResult_M = 64'h100;
        repeat (4) @(posedge clk);
        #1 valid_M = 1'b0; MemRead_M = 1'b0; reset = 1'b1;

        run_instr(1, 64'h100, 64'h0, 1'b0, 1'b0, 2, 2, 64'hDEADBEEF_CAFEF00D, 1'b0);
        run_instr(2, 64'h8, 64'h55, 1'b0, 1'b0, 0, 0, 64'h0, 1'b0);
        run_instr(2, 64'h103, 64'h77, 1'b0, 1'b0, 0, 0, 64'h0, 1'b0);
        run_instr(1, 64'h180, 64'h0, 1'b0, 1'b0, 20, 0, 64'h1111_2222_3333_4444, 1'b0);
        run_instr(0, 64'h18, 64'h0, 1'b1, 1'b1, 0, 0, 64'h0, 1'b0);
        run_instr(0, 64'h18, 64'h0, 1'b1, 1'b0, 0, 0, 64'h0, 1'b0);
        run_instr(1, 64'h40, 64'h0, 1'b0, 1'b0, 0, 0, 64'h0123_4567_89AB_CDEF, 1'b1);
        run_instr(1, 64'h48, 64'h0, 1'b0, 1'b0, 1, TO - 1, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0);
        run_instr(1, 64'h50, 64'h0, 1'b0, 1'b0, 1, TO, 64'hFFFF_0000_FFFF_0000, 1'b0);
        run_instr(2, 64'h58, 64'h99, 1'b0, 1'b0, TO - 1, 0, 64'h0, 1'b0);

        // Reset in the middle of an outstanding load: no completion may follow.
        begin
            exp_t e;
            @(posedge clk); #1;
            valid_M = 1'b1; MemRead_M = 1'b1; MemWrite_M = 1'b0; Branch_M = 1'b0;
            aluResult_M = 64'h200; dm_ready = 1'b0; dm_rvalid = 1'b0;
            e.addr = 64'h200; e.wdata = '0; e.we = 1'b0; e.has_req = 1'b1;
            e.issue = cyc; e.lat = 0; e.err = 2'b00; e.rdata = '0;
            sb.push_back(e);
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("midrst_req_before", 64'(dm_req), 64'd1);
            @(posedge clk); #1;
            reset = 1'b0; valid_M = 1'b0; MemRead_M = 1'b0;
            @(posedge clk); #1;
            reset = 1'b1;
            model_rd = '0;
            repeat (4) @(posedge clk);
        end

        for (int i = 0; i < 120; i++) begin
            int          kind;
            logic [63:0] a;
            kind = int'($urandom_range(0, 2));
            a    = {$urandom(), $urandom()};
            if ($urandom_range(0, 6) != 0) a[2:0] = 3'd0;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            run_instr(kind, a, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 5)), {$urandom(), $urandom()},
                      1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
